dual_deque_core: RTL and testbench
==================================

# dual_deque_core

Parametrised dual double-ended queue: two independent deques (A, B) of WIDTH-bit words, each DEPTH entries, driven by a single command port. It is the generalised successor of the dual-stack core: both ends of each queue are accessible, depth and width are parameters, and an inter-deque transfer operation is added. It sits behind the top-level pin adapter, which maps the 8-bit input, output and bidirectional pins onto the command and data ports.

## Interface
- WIDTH, 8, data word width (1..16)
- DEPTH, 16, entries per deque; power of two, 2..256; AW = log2(DEPTH)
- clk  in  1  system clock, all logic on rising edge
- rst  in  1  reset, synchronous, active-high
- cmd_valid  in  1  command strobe; one command per cycle, never back-pressured
- cmd_sel  in  1  target deque: 0 = A, 1 = B
- cmd_op  in  3  operation code (see Operation)
- cmd_data  in  WIDTH  push operand
- out_valid  out  1  result strobe, one cycle
- out_data  out  WIDTH  result word
- err  out  1  one-cycle pulse: previous command was illegal
- count_a, count_b  out  AW+1  occupancy, 0..DEPTH
- empty_a, full_a, empty_b, full_b  out  1  combinational decode of the counts

## Operation
- Per deque: storage array mem[DEPTH], front pointer F (index of the front element), back pointer K (next free slot at the back), count C. Pointers wrap modulo DEPTH.
- Op codes:
  - 0 NOP: no action.
  - 1 PUSH_FRONT: F←F-1, mem[F-1]←cmd_data, C+1.
  - 2 PUSH_BACK: mem[K]←cmd_data, K←K+1, C+1.
  - 3 POP_FRONT: result mem[F], F←F+1, C-1.
  - 4 POP_BACK: result mem[K-1], K←K-1, C-1.
  - 5 PEEK_FRONT: result mem[F]; no state change.
  - 6 XFER: pop the front of the selected deque and push that word onto the back of the other deque. Result is the moved word.
  - 7 CLEAR: F, K and C of the selected deque go to 0. Storage contents are not cleared.
- Illegal commands:
  - A pop, peek or XFER on an empty source.
  - A push on a full target, or XFER into a full destination.
  - Effect: err pulses, out_valid stays 0, and neither deque changes.
- CLEAR and NOP are always legal.
- cmd_valid=0 is equivalent to NOP, regardless of cmd_op.
- Deques are fully independent, except during XFER. One command touches at most the two deques, so there are no intra-cycle conflicts.
- A push at C=DEPTH-1 is legal and gives full=1. F==K is then ambiguous, so occupancy is decided only by C.

## Timing
- Commands are sampled on the rising edge of clk when cmd_valid=1.
- Pointer, count and storage updates take effect at that same edge. count, empty and full reflect the new state in the following cycle.
- out_valid, out_data and err are registered and appear in the cycle after the command (latency 1).
- out_data holds its last value while out_valid=0.
- Back-to-back commands are supported every cycle. A pop issued in the cycle after a push to the same end returns the just-pushed word (no hazard).
- Reset values: all F, K, C = 0; count_* = 0; empty_* = 1; full_* = 0; out_valid = 0; out_data = 0; err = 0.
- Storage is not reset.
- Reset asserted mid-sequence wins over any command in the same cycle. That command is dropped, and no out_valid or err is produced for it.
- err and out_valid are never high in the same cycle.

## Test plan
- Reset, then PUSH_BACK A 0x11, 0x22, 0x33, then POP_FRONT ×3 → out_data 0x11, 0x22, 0x33 (FIFO order), each with out_valid the cycle after its pop; count_a 3→0; empty_a=1.
- PUSH_FRONT B 0x01, 0x02, then POP_FRONT ×2 → 0x02, 0x01 (LIFO order).
- Wrap-around: PUSH_FRONT on an empty A → entry stored at index DEPTH-1. Then PUSH_BACK until full_a=1 after DEPTH pushes. One further push → err=1, count_a stays DEPTH. POP_BACK / POP_FRONT then return the correct end values.
- POP_FRONT on an empty B → err=1, out_valid=0, count_b=0. PEEK_FRONT after PUSH_BACK B 0x5A → out_data 0x5A, count_b stays 1.
- A = [0xAA, 0xBB], XFER sel=A → out_data 0xAA, count_a=1, count_b=1, and POP_BACK B returns 0xAA. XFER into a full B → err=1, both counts unchanged.
- Randomised command stream with DEPTH=4, WIDTH=8 against a behavioural deque model. Includes CLEAR mid-stream and rst asserted in the same cycle as a push (push dropped, all counts 0 the next cycle).

Source files
------------

// File: rtl/dual_deque_core.sv
// Two independent WIDTH x DEPTH deques behind one command port; results and err are registered (latency 1).
// Never back-pressures: illegal commands are dropped with a one-cycle err pulse and leave both deques untouched.
module dual_deque_core #(
  parameter int WIDTH = 8,
  parameter int DEPTH = 16,
  localparam int AW = $clog2(DEPTH)
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             cmd_valid,
  input  logic             cmd_sel,
  input  logic [2:0]       cmd_op,
  input  logic [WIDTH-1:0] cmd_data,
  output logic             out_valid,
  output logic [WIDTH-1:0] out_data,
  output logic             err,
  output logic [AW:0]      count_a,
  output logic [AW:0]      count_b,
  output logic             empty_a,
  output logic             full_a,
  output logic             empty_b,
  output logic             full_b
);

  localparam logic [2:0] OP_NOP        = 3'd0;
  localparam logic [2:0] OP_PUSH_FRONT = 3'd1;
  localparam logic [2:0] OP_PUSH_BACK  = 3'd2;
  localparam logic [2:0] OP_POP_FRONT  = 3'd3;
  localparam logic [2:0] OP_POP_BACK   = 3'd4;
  localparam logic [2:0] OP_PEEK_FRONT = 3'd5;
  localparam logic [2:0] OP_XFER       = 3'd6;
  localparam logic [2:0] OP_CLEAR      = 3'd7;

  localparam logic [AW:0]   FULL_CNT = (AW + 1)'(DEPTH);
  localparam logic [AW:0]   CNT_ONE  = (AW + 1)'(1);
  localparam logic [AW-1:0] PTR_ONE  = AW'(1);

  // Index 0 is deque A, index 1 is deque B.
  logic [WIDTH-1:0] mem   [2][DEPTH];
  logic [AW-1:0]    front [2];
  logic [AW-1:0]    back  [2];
  logic [AW:0]      cnt   [2];

  logic             src;
  logic             dst;
  logic             src_empty;
  logic             src_full;
  logic             dst_full;
  logic             legal;
  logic             has_result;
  logic             active;
  logic             commit;
  logic [AW-1:0]    front_m1;
  logic [AW-1:0]    back_m1;
  logic [WIDTH-1:0] rd_word;

  assign src = cmd_sel;
  assign dst = ~cmd_sel;

  always_comb begin
    src_empty  = (cnt[src] == '0);
    src_full   = (cnt[src] == FULL_CNT);
    dst_full   = (cnt[dst] == FULL_CNT);
    front_m1   = front[src] - PTR_ONE;
    back_m1    = back[src] - PTR_ONE;
    legal      = 1'b1;
    has_result = 1'b0;
    rd_word    = mem[src][front[src]];
    case (cmd_op)
      OP_PUSH_FRONT, OP_PUSH_BACK: legal = !src_full;
      OP_POP_FRONT, OP_PEEK_FRONT: begin
        legal      = !src_empty;
        has_result = 1'b1;
      end
      OP_POP_BACK: begin
        legal      = !src_empty;
        has_result = 1'b1;
        rd_word    = mem[src][back_m1];
      end
      OP_XFER: begin
        legal      = !src_empty && !dst_full;
        has_result = 1'b1;
      end
      default: legal = 1'b1;
    endcase
    // Reset takes priority: a command in a reset cycle is neither executed nor flagged.
    active = cmd_valid && !rst;
    commit = active && legal;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      for (int i = 0; i < 2; i++) begin
        front[i] <= '0;
        back[i]  <= '0;
        cnt[i]   <= '0;
      end
      out_valid <= 1'b0;
      out_data  <= '0;
      err       <= 1'b0;
    end else begin
      out_valid <= commit && has_result;
      err       <= active && !legal;
      if (commit && has_result) begin
        out_data <= rd_word;
      end
      if (commit) begin
        case (cmd_op)
          OP_PUSH_FRONT: begin
            front[src] <= front_m1;
            cnt[src]   <= cnt[src] + CNT_ONE;
          end
          OP_PUSH_BACK: begin
            back[src] <= back[src] + PTR_ONE;
            cnt[src]  <= cnt[src] + CNT_ONE;
          end
          OP_POP_FRONT: begin
            front[src] <= front[src] + PTR_ONE;
            cnt[src]   <= cnt[src] - CNT_ONE;
          end
          OP_POP_BACK: begin
            back[src] <= back_m1;
            cnt[src]  <= cnt[src] - CNT_ONE;
          end
          OP_XFER: begin
            front[src] <= front[src] + PTR_ONE;
            cnt[src]   <= cnt[src] - CNT_ONE;
            back[dst]  <= back[dst] + PTR_ONE;
            cnt[dst]   <= cnt[dst] + CNT_ONE;
          end
          OP_CLEAR: begin
            front[src] <= '0;
            back[src]  <= '0;
            cnt[src]   <= '0;
          end
          default: ;
        endcase
      end
    end
  end

  // Storage carries no reset; pointers alone define which words are live.
  always_ff @(posedge clk) begin
    if (commit) begin
      case (cmd_op)
        OP_PUSH_FRONT: mem[src][front_m1]   <= cmd_data;
        OP_PUSH_BACK:  mem[src][back[src]]  <= cmd_data;
        OP_XFER:       mem[dst][back[dst]]  <= rd_word;
        default: ;
      endcase
    end
  end

  assign count_a = cnt[0];
  assign count_b = cnt[1];
  assign empty_a = (cnt[0] == '0);
  assign full_a  = (cnt[0] == FULL_CNT);
  assign empty_b = (cnt[1] == '0);
  assign full_b  = (cnt[1] == FULL_CNT);

  a_excl: assert property (@(posedge clk) !(out_valid && err));
  a_cnt:  assert property (@(posedge clk) (cnt[0] <= FULL_CNT) && (cnt[1] <= FULL_CNT));

endmodule

// File: tb/tb_dual_deque_core.sv
// Bench for dual_deque_core (DEPTH=4, WIDTH=8): directed literal checks plus a random stream
// compared every cycle against a queue-based deque model.
module tb_dual_deque_core;
  localparam int WIDTH = 8;
  localparam int DEPTH = 4;
  localparam int AW    = 2;

  localparam logic [2:0] NOP = 3'd0, PUSH_F = 3'd1, PUSH_B = 3'd2, POP_F = 3'd3,
                         POP_B = 3'd4, PEEK = 3'd5, XFER = 3'd6, CLEAR = 3'd7;

  logic             clk = 1'b0;
  logic             rst;
  logic             cmd_valid;
  logic             cmd_sel;
  logic [2:0]       cmd_op;
  logic [WIDTH-1:0] cmd_data;
  logic             out_valid;
  logic [WIDTH-1:0] out_data;
  logic             err;
  logic [AW:0]      count_a;
  logic [AW:0]      count_b;
  logic             empty_a;
  logic             full_a;
  logic             empty_b;
  logic             full_b;

  dual_deque_core #(.WIDTH(WIDTH), .DEPTH(DEPTH)) dut (
    .clk(clk), .rst(rst), .cmd_valid(cmd_valid), .cmd_sel(cmd_sel), .cmd_op(cmd_op),
    .cmd_data(cmd_data), .out_valid(out_valid), .out_data(out_data), .err(err),
    .count_a(count_a), .count_b(count_b), .empty_a(empty_a), .full_a(full_a),
    .empty_b(empty_b), .full_b(full_b)
  );

  always #5 clk = ~clk;

  int n_tests = 0;
  int n_fail  = 0;
  bit chk_en  = 1'b0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s at %0t: got 0x%0h, expected 0x%0h", name, $time, act, exp);
    end
  endtask

  // Behavioural model: each deque is a plain queue, front at index 0.
  logic [7:0] qa[$];
  logic [7:0] qb[$];
  logic       m_ov   = 1'b0;
  logic       m_err  = 1'b0;
  logic [7:0] m_data = 8'h00;

  task automatic model_step(input logic sel, input logic [2:0] op, input logic [7:0] d);
    int ns;
    int no;
    logic [7:0] w;
    ns = sel ? qb.size() : qa.size();
    no = sel ? qa.size() : qb.size();
    w  = 8'h00;
    case (op)
      PUSH_F, PUSH_B: begin
        if (ns == DEPTH) m_err = 1'b1;
        else if (op == PUSH_F) begin
          if (sel) qb.push_front(d); else qa.push_front(d);
        end else begin
          if (sel) qb.push_back(d); else qa.push_back(d);
        end
      end
      POP_F, POP_B, PEEK: begin
        if (ns == 0) m_err = 1'b1;
        else begin
          if (op == POP_F) w = sel ? qb.pop_front() : qa.pop_front();
          else if (op == POP_B) w = sel ? qb.pop_back() : qa.pop_back();
          else w = sel ? qb[0] : qa[0];
          m_ov = 1'b1;
          m_data = w;
        end
      end
      XFER: begin
        if (ns == 0 || no == DEPTH) m_err = 1'b1;
        else begin
          if (sel) begin w = qb.pop_front(); qa.push_back(w); end
          else begin w = qa.pop_front(); qb.push_back(w); end
          m_ov = 1'b1;
          m_data = w;
        end
      end
      CLEAR: begin
        if (sel) qb.delete(); else qa.delete();
      end
      default: ;
    endcase
  endtask

  always @(posedge clk) begin
    if (rst) begin
      qa.delete();
      qb.delete();
      m_ov   = 1'b0;
      m_err  = 1'b0;
      m_data = 8'h00;
    end else begin
      m_ov  = 1'b0;
      m_err = 1'b0;
      if (cmd_valid) model_step(cmd_sel, cmd_op, cmd_data);
    end
  end

  always @(negedge clk) begin
    if (chk_en) begin
      chk("out_valid", 32'(out_valid), 32'(m_ov));
      chk("err", 32'(err), 32'(m_err));
      chk("out_data", 32'(out_data), 32'(m_data));
      chk("count_a", 32'(count_a), qa.size());
      chk("count_b", 32'(count_b), qb.size());
      chk("empty_a", 32'(empty_a), 32'(qa.size() == 0));
      chk("full_a", 32'(full_a), 32'(qa.size() == DEPTH));
      chk("empty_b", 32'(empty_b), 32'(qb.size() == 0));
      chk("full_b", 32'(full_b), 32'(qb.size() == DEPTH));
    end
  end

  // Drives one command for one cycle; on return the DUT outputs reflect that command.
  task automatic cmd(input logic sel, input logic [2:0] op, input logic [7:0] d);
    cmd_valid = 1'b1;
    cmd_sel   = sel;
    cmd_op    = op;
    cmd_data  = d;
    @(negedge clk);
    cmd_valid = 1'b0;
    cmd_op    = NOP;
  endtask

  task automatic expect_res(input string name, input logic [7:0] d);
    chk({name, "_valid"}, 32'(out_valid), 32'd1);
    chk({name, "_data"}, 32'(out_data), 32'(d));
  endtask

  task automatic expect_err(input string name);
    chk({name, "_err"}, 32'(err), 32'd1);
    chk({name, "_noval"}, 32'(out_valid), 32'd0);
  endtask

  initial begin
    int r;
    logic [2:0] op;
    rst = 1'b1; cmd_valid = 1'b0; cmd_sel = 1'b0; cmd_op = NOP; cmd_data = 8'h00;
    @(negedge clk);
    @(negedge clk);
    chk_en = 1'b1;
    chk("rst_count_a", 32'(count_a), 0);
    chk("rst_empty_a", 32'(empty_a), 1);
    chk("rst_full_a", 32'(full_a), 0);
    chk("rst_out_valid", 32'(out_valid), 0);
    chk("rst_out_data", 32'(out_data), 0);
    chk("rst_err", 32'(err), 0);
    rst = 1'b0;

    // FIFO order through A.
    cmd(0, PUSH_B, 8'h11); cmd(0, PUSH_B, 8'h22); cmd(0, PUSH_B, 8'h33);
    chk("fifo_count3", 32'(count_a), 3);
    cmd(0, POP_F, 0); expect_res("fifo0", 8'h11);
    cmd(0, POP_F, 0); expect_res("fifo1", 8'h22);
    cmd(0, POP_F, 0); expect_res("fifo2", 8'h33);
    chk("fifo_count0", 32'(count_a), 0);
    chk("fifo_empty", 32'(empty_a), 1);

    // LIFO order through the front of B.
    cmd(1, PUSH_F, 8'h01); cmd(1, PUSH_F, 8'h02);
    cmd(1, POP_F, 0); expect_res("lifo0", 8'h02);
    cmd(1, POP_F, 0); expect_res("lifo1", 8'h01);

    // Wrap-around from a freshly cleared A, fill, overflow, drain both ends.
    cmd(0, CLEAR, 0);
    cmd(0, PUSH_F, 8'hA0);
    chk("wrap_count1", 32'(count_a), 1);
    cmd(0, PUSH_B, 8'hB1); cmd(0, PUSH_B, 8'hB2);
    chk("wrap_notfull", 32'(full_a), 0);
    cmd(0, PUSH_B, 8'hB3);
    chk("wrap_full", 32'(full_a), 1);
    chk("wrap_count4", 32'(count_a), 4);
    cmd(0, PUSH_B, 8'hEE); expect_err("overflow");
    chk("overflow_count", 32'(count_a), 4);
    cmd(0, PUSH_F, 8'hEF); expect_err("overflow_f");
    cmd(0, POP_B, 0); expect_res("wrap_back", 8'hB3);
    cmd(0, POP_F, 0); expect_res("wrap_front", 8'hA0);
    cmd(0, POP_F, 0); expect_res("wrap_front2", 8'hB1);
    cmd(0, POP_B, 0); expect_res("wrap_back2", 8'hB2);
    chk("wrap_empty", 32'(empty_a), 1);

    // Underflow and peek on B.
    cmd(1, POP_F, 0); expect_err("underflow");
    chk("underflow_count", 32'(count_b), 0);
    cmd(1, PUSH_B, 8'h5A);
    cmd(1, PEEK, 0); expect_res("peek", 8'h5A);
    chk("peek_count", 32'(count_b), 1);
    cmd(1, CLEAR, 0);
    chk("clear_b", 32'(count_b), 0);

    // Transfer A -> B, then into a full B.
    cmd(0, PUSH_B, 8'hAA); cmd(0, PUSH_B, 8'hBB);
    cmd(0, XFER, 0); expect_res("xfer", 8'hAA);
    chk("xfer_count_a", 32'(count_a), 1);
    chk("xfer_count_b", 32'(count_b), 1);
    cmd(1, POP_B, 0); expect_res("xfer_popb", 8'hAA);
    for (int i = 0; i < DEPTH; i++) cmd(1, PUSH_B, 8'(i + 1));
    cmd(0, XFER, 0); expect_err("xfer_full");
    chk("xfer_full_a", 32'(count_a), 1);
    chk("xfer_full_b", 32'(count_b), 4);
    cmd(1, XFER, 0); expect_res("xfer_ba", 8'h01);
    chk("xfer_ba_count_a", 32'(count_a), 2);

    // Reset in the same cycle as a push drops the push.
    rst = 1'b1; cmd_valid = 1'b1; cmd_sel = 1'b0; cmd_op = PUSH_B; cmd_data = 8'h77;
    @(negedge clk);
    rst = 1'b0; cmd_valid = 1'b0; cmd_op = NOP;
    chk("rstpush_count_a", 32'(count_a), 0);
    chk("rstpush_count_b", 32'(count_b), 0);
    chk("rstpush_ov", 32'(out_valid), 0);
    chk("rstpush_err", 32'(err), 0);

    // Random stream against the model.
    for (int i = 0; i < 3000; i++) begin
      r = $urandom_range(0, 15);
      if (r < 4) op = PUSH_B;
      else if (r < 6) op = PUSH_F;
      else if (r < 8) op = POP_F;
      else if (r < 10) op = POP_B;
      else if (r < 11) op = PEEK;
      else if (r < 13) op = XFER;
      else if (r < 14) op = CLEAR;
      else op = NOP;
      if ($urandom_range(0, 63) == 0) begin
        rst = 1'b1; cmd_valid = 1'b1; cmd_sel = 1'($urandom_range(0, 1));
        cmd_op = PUSH_B; cmd_data = 8'($urandom);
        @(negedge clk);
        rst = 1'b0; cmd_valid = 1'b0;
        chk("rnd_rst_a", 32'(count_a), 0);
        chk("rnd_rst_b", 32'(count_b), 0);
      end else begin
        cmd_valid = ($urandom_range(0, 9) != 0);
        cmd_sel   = 1'($urandom_range(0, 1));
        cmd_op    = op;
        cmd_data  = 8'($urandom);
        @(negedge clk);
      end
    end
    cmd_valid = 1'b0;
    @(negedge clk);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
